// File: rtl/ysyx_23060236_issue_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ysyx_23060236_issue_ctrl_pkg                                |
// | Purpose: shared types/constants for the IDU->EXU issue controller.   |
// |          Issue FSM state codes, register index width, x0 helper.     |
// | Ports  : none (package)                                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package ysyx_23060236_issue_ctrl_pkg;

  localparam int REG_IDX_W = 4;

  typedef enum logic [1:0] {
    ISSUE_RUN   = 2'd0,
    ISSUE_FLUSH = 2'd1,
    ISSUE_DRAIN = 2'd2,
    ISSUE_FENCE = 2'd3
  } issue_state_e;

  // x0 is hard-wired zero, so it never carries a dependency.
  function automatic logic reg_tracked(input logic [REG_IDX_W-1:0] idx);
    return idx != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060236_issue_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ysyx_23060236_issue_ctrl_if                                 |
// | Purpose: bundle of IDU/EXU/WB/I-cache signals around the issue ctrl. |
// | Ports  : master = pipeline environment (IDU, EXU, WB, I-cache)       |
// |          slave  = issue controller                                   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface ysyx_23060236_issue_ctrl_if;
  import ysyx_23060236_issue_ctrl_pkg::*;

  logic                 idu_valid;
  logic                 idu_ready;
  logic [REG_IDX_W-1:0] idu_rs1;
  logic [REG_IDX_W-1:0] idu_rs2;
  logic                 idu_rs1_used;
  logic                 idu_rs2_used;
  logic [REG_IDX_W-1:0] idu_rd;
  logic                 idu_reg_wen;
  logic                 idu_fencei;
  logic                 exu_valid;
  logic                 exu_ready;
  logic                 wb_valid;
  logic [REG_IDX_W-1:0] wb_rd;
  logic                 jump_wrong;
  logic                 icache_flush_req;
  logic                 icache_flush_done;
  logic                 sb_err;

  modport master (
    output idu_valid, idu_rs1, idu_rs2, idu_rs1_used, idu_rs2_used,
           idu_rd, idu_reg_wen, idu_fencei, exu_ready, wb_valid, wb_rd,
           jump_wrong, icache_flush_done,
    input  idu_ready, exu_valid, icache_flush_req, sb_err
  );

  modport slave (
    input  idu_valid, idu_rs1, idu_rs2, idu_rs1_used, idu_rs2_used,
           idu_rd, idu_reg_wen, idu_fencei, exu_ready, wb_valid, wb_rd,
           jump_wrong, icache_flush_done,
    output idu_ready, exu_valid, icache_flush_req, sb_err
  );

endinterface
`default_nettype wire

// File: rtl/ysyx_23060236_issue_ctrl_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ysyx_23060236_issue_ctrl_scoreboard                         |
// | Purpose: per-register in-flight write counters with RAW/WAW query.   |
// | Ports  : clock, reset (sync, active-low)                             |
// |          rs1/rs2/rd (+used/wen) : hazard query for the IDU instr     |
// |          inc  : issued instr writes rd      dec/dec_rd : retire      |
// |          hazard, all_clear, err (sticky underflow)                   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ysyx_23060236_issue_ctrl_scoreboard
  import ysyx_23060236_issue_ctrl_pkg::*;
#(
  parameter int NREG  = 16,
  parameter int CNT_W = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic                 rs1_used,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic                 rs2_used,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic                 reg_wen,
  input  logic                 inc,
  input  logic                 dec,
  input  logic [REG_IDX_W-1:0] dec_rd,
  output logic                 hazard,
  output logic                 all_clear,
  output logic                 err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic [NREG-1:0]  zero_vec;

  // Entry 0 is never selected, so x0 writes/retires are ignored.
  always_comb begin
    inc_vec  = '0;
    dec_vec  = '0;
    zero_vec = '0;
    for (int i = 0; i < NREG; i++) begin
      zero_vec[i] = (cnt[i] == '0);
    end
    for (int i = 1; i < NREG; i++) begin
      inc_vec[i] = inc && (rd == REG_IDX_W'(i));
      dec_vec[i] = dec && (dec_rd == REG_IDX_W'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
      err <= 1'b0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        // Simultaneous issue+retire on one register nets to zero.
        case ({inc_vec[i], dec_vec[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   if (!zero_vec[i]) cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
      // A lone retire on an idle register means the pipeline lost track.
      err <= err | (|(dec_vec & ~inc_vec & zero_vec));
    end
  end

  // Counter full is the only WAW limit; the hazard keeps inc from wrapping.
  always_comb begin
    hazard = (rs1_used && reg_tracked(rs1) && !zero_vec[rs1])
          || (rs2_used && reg_tracked(rs2) && !zero_vec[rs2])
          || (reg_wen  && reg_tracked(rd)  && (cnt[rd] == CNT_MAX));
    all_clear = &zero_vec;
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060236_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ysyx_23060236_issue_ctrl                                    |
// | Purpose: gates IDU->EXU issue on register hazards, kills wrong-path  |
// |          issue after jump_wrong, drains and flushes I-cache on       |
// |          fence.i.                                                    |
// | Ports  : clock, reset (sync, active-low), bus (slave modport)        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ysyx_23060236_issue_ctrl
  import ysyx_23060236_issue_ctrl_pkg::*;
#(
  parameter int NREG         = 16,  // must equal 2**REG_IDX_W
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 1    // >= 1
) (
  input  logic                        clock,
  input  logic                        reset,
  ysyx_23060236_issue_ctrl_if.slave   bus
);

  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
  // The jump_wrong cycle is itself the first blocked cycle.
  localparam logic [FCNT_W-1:0] FLUSH_REST = FCNT_W'(FLUSH_CYCLES - 1);
  // After a fence the redirect bubble has not been served yet.
  localparam logic [FCNT_W-1:0] FLUSH_FULL = FCNT_W'(FLUSH_CYCLES);

  issue_state_e      state;
  logic [FCNT_W-1:0] flush_cnt;
  logic              jw_pending;
  logic              flush_req;
  logic              hazard;
  logic              all_clear;
  logic              stall;
  logic              fire;

  assign stall         = !reset || (state != ISSUE_RUN) || bus.jump_wrong || hazard;
  assign bus.exu_valid = bus.idu_valid && !stall;
  assign bus.idu_ready = bus.exu_ready && !stall;
  assign fire          = bus.exu_valid && bus.exu_ready;
  assign bus.icache_flush_req = flush_req;

  ysyx_23060236_issue_ctrl_scoreboard #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_sb (
    .clock     (clock),
    .reset     (reset),
    .rs1       (bus.idu_rs1),
    .rs1_used  (bus.idu_rs1_used),
    .rs2       (bus.idu_rs2),
    .rs2_used  (bus.idu_rs2_used),
    .rd        (bus.idu_rd),
    .reg_wen   (bus.idu_reg_wen),
    .inc       (fire && bus.idu_reg_wen),
    .dec       (bus.wb_valid),
    .dec_rd    (bus.wb_rd),
    .hazard    (hazard),
    .all_clear (all_clear),
    .err       (bus.sb_err)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ISSUE_RUN;
      flush_cnt  <= '0;
      jw_pending <= 1'b0;
      flush_req  <= 1'b0;
    end else begin
      case (state)
        ISSUE_RUN: begin
          if (bus.jump_wrong) begin
            flush_cnt <= FLUSH_REST;
            state     <= (FLUSH_CYCLES > 1) ? ISSUE_FLUSH : ISSUE_RUN;
          end else if (fire && bus.idu_fencei) begin
            state <= ISSUE_DRAIN;
          end
        end
        ISSUE_FLUSH: begin
          if (bus.jump_wrong) begin
            flush_cnt <= FLUSH_REST;
            state     <= (FLUSH_CYCLES > 1) ? ISSUE_FLUSH : ISSUE_RUN;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
            if (flush_cnt == FCNT_W'(1)) state <= ISSUE_RUN;
          end
        end
        ISSUE_DRAIN: begin
          // The redirect is deferred until the fence completes.
          if (bus.jump_wrong) jw_pending <= 1'b1;
          if (all_clear) begin
            flush_req <= 1'b1;
            state     <= ISSUE_FENCE;
          end
        end
        ISSUE_FENCE: begin
          if (bus.icache_flush_done) begin
            flush_req  <= 1'b0;
            jw_pending <= 1'b0;
            if (jw_pending || bus.jump_wrong) begin
              flush_cnt <= FLUSH_FULL;
              state     <= ISSUE_FLUSH;
            end else begin
              state <= ISSUE_RUN;
            end
          end else if (bus.jump_wrong) begin
            jw_pending <= 1'b1;
          end
        end
        default: state <= ISSUE_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060236_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_ysyx_23060236_issue_ctrl                                 |
// | Purpose: directed stimulus with a cycle-level behavioural model and  |
// |          literal expectations for the issue controller.              |
// | Ports  : none                                                        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_ysyx_23060236_issue_ctrl;

  localparam int FC   = 3;
  localparam int MAXP = 3;

  logic clock;
  logic reset;
  ysyx_23060236_issue_ctrl_if bus ();

  ysyx_23060236_issue_ctrl #(
    .NREG         (16),
    .CNT_W        (2),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pend[r]    : writes to r issued but not yet retired
  // flush_left : cycles still blocked by a redirect after the current one
  // phase      : 0 normal, 1 waiting for writes to drain, 2 waiting on I-cache
  int pend [16];
  bit m_err;
  int flush_left;
  int phase;
  bit owed;
  bit model_ok = 1'b0;
  int d [16];
  bit mf;
  int total;

  function automatic bit m_blocked();
    bit hz;
    hz = (bus.idu_rs1_used && bus.idu_rs1 != 0 && pend[bus.idu_rs1] > 0)
      || (bus.idu_rs2_used && bus.idu_rs2 != 0 && pend[bus.idu_rs2] > 0)
      || (bus.idu_reg_wen  && bus.idu_rd  != 0 && pend[bus.idu_rd] >= MAXP);
    return !reset || phase != 0 || flush_left > 0 || bus.jump_wrong || hz;
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      if (!reset) begin
        for (int i = 0; i < 16; i++) pend[i] = 0;
        m_err = 0; flush_left = 0; phase = 0; owed = 0;
      end else begin
        mf = bus.idu_valid && !m_blocked() && bus.exu_ready;
        total = 0;
        for (int i = 0; i < 16; i++) total += pend[i];
        case (phase)
          0: begin
            if (bus.jump_wrong)        flush_left = FC - 1;
            else if (flush_left > 0)   flush_left--;
            else if (mf && bus.idu_fencei) phase = 1;
          end
          1: begin
            if (bus.jump_wrong) owed = 1;
            if (total == 0) phase = 2;
          end
          default: begin
            if (bus.jump_wrong) owed = 1;
            if (bus.icache_flush_done) begin
              phase = 0;
              if (owed) begin flush_left = FC; owed = 0; end
            end
          end
        endcase
        for (int i = 0; i < 16; i++) d[i] = 0;
        if (mf && bus.idu_reg_wen && bus.idu_rd != 0) d[bus.idu_rd] += 1;
        if (bus.wb_valid && bus.wb_rd != 0) d[bus.wb_rd] -= 1;
        for (int i = 0; i < 16; i++) begin
          if (pend[i] + d[i] < 0) begin m_err = 1; pend[i] = 0; end
          else pend[i] = pend[i] + d[i];
        end
      end
      model_ok = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    wait (model_ok);
    forever begin
      @(negedge clock);
      check("exu_valid", bus.exu_valid, bus.idu_valid && !m_blocked());
      check("idu_ready", bus.idu_ready, bus.exu_ready && !m_blocked());
      check("flush_req", bus.icache_flush_req, phase == 2);
      check("sb_err",    bus.sb_err, m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    bus.idu_valid = 0; bus.idu_rs1 = 0; bus.idu_rs2 = 0;
    bus.idu_rs1_used = 0; bus.idu_rs2_used = 0; bus.idu_rd = 0;
    bus.idu_reg_wen = 0; bus.idu_fencei = 0; bus.exu_ready = 1;
    bus.wb_valid = 0; bus.wb_rd = 0; bus.jump_wrong = 0;
    bus.icache_flush_done = 0;
  endtask

  task automatic instr(input logic [3:0] rs1, input logic u1,
                       input logic [3:0] rs2, input logic u2,
                       input logic [3:0] rd, input logic wen, input logic fi);
    bus.idu_valid = 1; bus.idu_rs1 = rs1; bus.idu_rs1_used = u1;
    bus.idu_rs2 = rs2; bus.idu_rs2_used = u2; bus.idu_rd = rd;
    bus.idu_reg_wen = wen; bus.idu_fencei = fi;
  endtask

  task automatic wb(input logic [3:0] r);
    bus.wb_valid = 1; bus.wb_rd = r;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0;
    clr();
    // reset: nothing may issue while reset is low
    tick(); clr(); instr(0,0,0,0,0,0,0); settle();
    check("rst_exu_valid", bus.exu_valid, 0);
    check("rst_idu_ready", bus.idu_ready, 0);
    tick(); settle();
    check("rst_sb_err", bus.sb_err, 0);
    check("rst_req", bus.icache_flush_req, 0);

    // 1: RAW stall on x5, released one cycle after its writeback
    tick(); reset = 1; clr(); instr(0,0,0,0,5,1,0); settle();
    check("t1_issue", bus.exu_valid, 1);
    tick(); clr(); instr(5,1,0,0,0,0,0); wb(5); settle();
    check("t1_raw_valid", bus.exu_valid, 0);
    check("t1_raw_ready", bus.idu_ready, 0);
    tick(); clr(); instr(5,1,0,0,0,0,0); settle();
    check("t1_after_wb", bus.exu_valid, 1);

    // 2: x0 never stalls; fourth pending write to x7 stalls
    tick(); clr(); instr(0,1,0,1,0,1,0); settle();
    check("t2_x0", bus.exu_valid, 1);
    for (int k = 0; k < 3; k++) begin
      tick(); clr(); instr(0,0,0,0,7,1,0); settle();
      check("t2_w7", bus.exu_valid, 1);
    end
    tick(); clr(); instr(0,0,0,0,7,1,0); settle();
    check("t2_w7_full", bus.exu_valid, 0);
    for (int k = 0; k < 3; k++) begin
      tick(); clr(); wb(7);
    end
    tick(); clr(); instr(0,0,7,1,0,0,0); settle();
    check("t2_drained", bus.exu_valid, 1);

    // 3: same-cycle inc/dec keeps count; retire on idle x4 sets sticky err
    tick(); clr(); instr(0,0,0,0,9,1,0); settle();
    check("t3_first", bus.exu_valid, 1);
    tick(); clr(); instr(0,0,0,0,9,1,0); wb(9); settle();
    check("t3_same", bus.exu_valid, 1);
    tick(); clr(); instr(9,1,0,0,0,0,0); wb(9); settle();
    check("t3_one_left", bus.exu_valid, 0);
    tick(); clr(); instr(9,1,0,0,0,0,0); settle();
    check("t3_zero", bus.exu_valid, 1);
    tick(); clr(); wb(4); settle();
    check("t3_err_pre", bus.sb_err, 0);
    tick(); clr(); settle();
    check("t3_err", bus.sb_err, 1);
    tick(); tick(); settle();
    check("t3_sticky", bus.sb_err, 1);

    // 4: jump_wrong blocks exactly FC cycles including its own
    tick(); clr(); instr(0,0,0,0,0,0,0); bus.jump_wrong = 1; settle();
    check("t4_jw", bus.exu_valid, 0);
    tick(); clr(); instr(0,0,0,0,0,0,0); settle();
    check("t4_b2", bus.exu_valid, 0);
    tick(); settle();
    check("t4_b3", bus.exu_valid, 0);
    tick(); settle();
    check("t4_resume", bus.exu_valid, 1);

    // 5: fence.i waits for two x3 retires, then flush handshake
    tick(); clr(); instr(0,0,0,0,3,1,0);
    tick(); clr(); instr(0,0,0,0,3,1,0);
    tick(); clr(); instr(0,0,0,0,0,0,1); settle();
    check("t5_fence_issue", bus.exu_valid, 1);
    tick(); clr(); instr(0,0,0,0,0,0,0); settle();
    check("t5_younger_blk", bus.exu_valid, 0);
    check("t5_req0_a", bus.icache_flush_req, 0);
    tick(); clr(); instr(0,0,0,0,0,0,0); wb(3); settle();
    check("t5_req0_b", bus.icache_flush_req, 0);
    tick(); clr(); instr(0,0,0,0,0,0,0); wb(3); settle();
    check("t5_req0_c", bus.icache_flush_req, 0);
    tick(); clr(); instr(0,0,0,0,0,0,0); settle();
    check("t5_req0_d", bus.icache_flush_req, 0);
    tick(); settle();
    check("t5_req1", bus.icache_flush_req, 1);
    tick(); tick(); tick(); settle();
    check("t5_req_held", bus.icache_flush_req, 1);
    tick(); bus.icache_flush_done = 1; settle();
    check("t5_req_at_done", bus.icache_flush_req, 1);
    tick(); bus.icache_flush_done = 0; settle();
    check("t5_req_dropped", bus.icache_flush_req, 0);
    check("t5_run", bus.exu_valid, 1);

    // 5b: jump_wrong during drain turns into a full bubble after the fence
    tick(); clr(); instr(0,0,0,0,0,0,1);
    tick(); clr(); instr(0,0,0,0,0,0,0); bus.jump_wrong = 1;
    tick(); clr(); instr(0,0,0,0,0,0,0); bus.icache_flush_done = 1; settle();
    check("t5b_req", bus.icache_flush_req, 1);
    for (int k = 0; k < FC; k++) begin
      tick(); clr(); instr(0,0,0,0,0,0,0); settle();
      check("t5b_bubble", bus.exu_valid, 0);
    end
    tick(); settle();
    check("t5b_resume", bus.exu_valid, 1);

    // 6: reset in DRAIN clears counters; reset in FENCE drops req
    tick(); clr(); instr(0,0,0,0,6,1,0);
    tick(); clr(); instr(0,0,0,0,0,0,1);
    tick(); clr(); instr(0,0,0,0,0,0,0); settle();
    check("t6_drain_blk", bus.exu_valid, 0);
    tick(); reset = 0; settle();
    check("t6_rst_blk", bus.exu_valid, 0);
    tick(); reset = 1; clr(); instr(6,1,0,0,0,0,0); settle();
    check("t6_cnt_clear", bus.exu_valid, 1);
    check("t6_err_clear", bus.sb_err, 0);
    tick(); clr(); instr(0,0,0,0,0,0,1);
    tick(); clr(); instr(0,0,0,0,0,0,0);
    tick(); settle();
    check("t6_req1", bus.icache_flush_req, 1);
    tick(); reset = 0; settle();
    check("t6_rst_valid", bus.exu_valid, 0);
    tick(); reset = 1; settle();
    check("t6_req_abort", bus.icache_flush_req, 0);
    check("t6_run", bus.exu_valid, 1);

    tick(); clr();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
